// File: rtl/display_bcd_sequencer.sv
// Converts a 32-bit IO word to eight seven-segment digit patterns using a serial
// double-dabble conversion, with a busy/done handshake and a one-deep request buffer.
module display_bcd_sequencer #(
  parameter bit BLANK_LEADING  = 1'b0,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_req,
  input  logic [31:0] io_data,
  output logic        busy,
  output logic        done,
  output logic        pending,
  output logic        overflow,
  output logic [55:0] seg
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StConvert = 2'd1;
  localparam logic [1:0] StLatch   = 2'd2;

  localparam logic [6:0]  SegZero   = SEG_ACTIVE_LOW ? 7'h40 : 7'h3F;
  localparam logic [55:0] SegReset  = {8{SegZero}};

  logic [1:0]  state_q;
  logic [31:0] shreg_q;
  logic [39:0] bcd_q;
  logic [4:0]  count_q;
  logic [31:0] pend_data_q;
  logic        pending_q;
  logic        done_q;
  logic        overflow_q;
  logic [55:0] seg_q;

  logic [39:0] bcd_adj;
  logic [39:0] bcd_shift;
  logic [31:0] shreg_shift;
  logic        ovf_new;
  logic [55:0] seg_new;
  logic        lead;
  logic [6:0]  pat;

  function automatic logic [6:0] encode(input logic [3:0] d);
    logic [6:0] p;
    unique case (d)
      4'd0:    p = 7'h40;
      4'd1:    p = 7'h79;
      4'd2:    p = 7'h24;
      4'd3:    p = 7'h30;
      4'd4:    p = 7'h19;
      4'd5:    p = 7'h12;
      4'd6:    p = 7'h02;
      4'd7:    p = 7'h78;
      4'd8:    p = 7'h00;
      4'd9:    p = 7'h10;
      default: p = 7'h7F;
    endcase
    return p;
  endfunction

  // Add-3 on every nibble >= 5, then one left shift of {bcd, shreg}
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 10; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    bcd_shift   = {bcd_adj[38:0], shreg_q[31]};
    shreg_shift = {shreg_q[30:0], 1'b0};
  end

  // Blanking walks down from digit 7 and stops at the first nonzero digit
  always_comb begin
    ovf_new = |bcd_q[39:32];
    seg_new = '0;
    lead    = 1'b1;
    pat     = '0;
    for (int d = 7; d >= 0; d--) begin
      pat = encode(bcd_q[4*d +: 4]);
      if (BLANK_LEADING && !ovf_new && d > 0 && lead && bcd_q[4*d +: 4] == 4'd0) begin
        pat = 7'h7F;
      end else begin
        lead = 1'b0;
      end
      seg_new[7*d +: 7] = SEG_ACTIVE_LOW ? pat : ~pat;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      shreg_q     <= '0;
      bcd_q       <= '0;
      count_q     <= '0;
      pend_data_q <= '0;
      pending_q   <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      seg_q       <= SegReset;
    end else begin
      done_q <= (state_q == StLatch);
      unique case (state_q)
        StIdle: begin
          if (io_req) begin
            shreg_q <= io_data;
            bcd_q   <= '0;
            count_q <= '0;
            state_q <= StConvert;
          end
        end
        StConvert: begin
          if (io_req) begin
            pend_data_q <= io_data;
            pending_q   <= 1'b1;
          end
          bcd_q   <= bcd_shift;
          shreg_q <= shreg_shift;
          count_q <= count_q + 5'd1;
          if (count_q == 5'd31) begin
            state_q <= StLatch;
          end
        end
        StLatch: begin
          seg_q      <= seg_new;
          overflow_q <= ovf_new;
          bcd_q      <= '0;
          count_q    <= '0;
          if (io_req) begin
            // A fresh request supersedes anything buffered
            shreg_q   <= io_data;
            pending_q <= 1'b0;
            state_q   <= StConvert;
          end else if (pending_q) begin
            shreg_q   <= pend_data_q;
            pending_q <= 1'b0;
            state_q   <= StConvert;
          end else begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy     = (state_q == StConvert) || (state_q == StLatch);
  assign done     = done_q;
  assign pending  = pending_q;
  assign overflow = overflow_q;
  assign seg      = seg_q;

endmodule
